// File: rtl/sa_pkg.sv
// Shared types and arithmetic helpers for the systolic-array job interface.
// Imported by both the responder engine and wrapper-side checkers.
package sa_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sa_state_e;

    // Accumulator width that cannot overflow when summing k_max full-width products.
    function automatic int unsigned calc_acc_w(input int unsigned d_w, input int unsigned k_max);
        return 2 * d_w + $clog2(k_max);
    endfunction

    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v,
                                                  input int unsigned     d_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (d_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (d_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sa_mac_lane.sv
// One signed multiply-accumulate lane with a clear input and a saturated, shifted result.
module sa_mac_lane
    import sa_pkg::*;
#(
    parameter int unsigned D_W   = 8,
    parameter int unsigned ACC_W = 23,
    parameter int unsigned FRAC  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  last_i,
    input  logic signed [D_W-1:0] x_i,
    input  logic signed [D_W-1:0] w_i,
    output logic signed [D_W-1:0] res_o
);

    logic signed [2*D_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        prod    = (2*D_W)'(x_i) * (2*D_W)'(w_i);
        sum     = acc_q + ACC_W'(prod);
        shifted = sum >>> FRAC;
        // res_o already includes the current product so the row can be stored this cycle.
        res_o   = D_W'(sat_dw(64'(shifted), D_W));
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = last_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sa_seq_responder.sv
// Time-multiplexed matrix-multiply responder: one row of SA_C MAC lanes steps through
// every (row, k) pair of X x W and stores each saturated row as soon as it completes.
module sa_seq_responder
    import sa_pkg::*;
#(
    parameter int unsigned D_W   = 8,
    parameter int unsigned SA_R  = 16,
    parameter int unsigned SA_C  = 16,
    parameter int unsigned K_MAX = 128,
    parameter int unsigned FRAC  = 0
) (
    input  logic                                     I_CLK,
    input  logic                                     I_ASYN_RSTN,
    input  logic                                     I_SYNC_RSTN,
    input  logic                                     I_START_FLAG,
    input  logic [7:0]                               I_M_DIM,
    input  logic [0:SA_R-1][0:K_MAX-1][D_W-1:0]      I_X_MATRIX,
    input  logic [0:K_MAX-1][0:SA_C-1][D_W-1:0]      I_W_MATRIX,
    output logic                                     O_OUT_VLD,
    output logic                                     O_PE_SHIFT,
    output logic                                     O_BUSY,
    output logic [0:SA_R-1][0:SA_C-1][D_W-1:0]       O_OUT
);

    localparam int unsigned ACC_W = calc_acc_w(D_W, K_MAX);
    localparam int unsigned RW    = (SA_R > 1) ? $clog2(SA_R) : 1;
    localparam int unsigned KIW   = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(SA_R - 1);

    sa_state_e                           state_q;
    logic [RW-1:0]                       i_q;
    logic [KIW-1:0]                      k_q;
    // Effective inner dimension is held as Meff-1; a zero-length job never enters RUN.
    logic [KIW-1:0]                      last_k_q;
    logic                                vld_q;
    logic                                shift_q;
    logic                                busy_q;
    logic [0:SA_R-1][0:SA_C-1][D_W-1:0]  out_q;

    logic                                m_zero;
    logic [KIW-1:0]                      last_k_w;
    logic                                row_end;
    logic                                job_end;
    logic [RW-1:0]                       i_nxt;
    logic [KIW-1:0]                      k_nxt;
    logic                                nxt_last;
    logic                                lane_clr;
    logic                                lane_en;
    logic [D_W-1:0]                      x_cur;
    logic [0:SA_C-1][D_W-1:0]            row_res;

    always_comb begin
        m_zero = (I_M_DIM == 8'd0);
        if (32'(I_M_DIM) >= K_MAX) begin
            last_k_w = KIW'(K_MAX - 1);
        end else begin
            last_k_w = KIW'(I_M_DIM - 8'd1);
        end
    end

    always_comb begin
        row_end = (k_q == last_k_q);
        job_end = row_end && (i_q == LAST_ROW);
        if (row_end) begin
            i_nxt = i_q + RW'(1);
            k_nxt = '0;
        end else begin
            i_nxt = i_q;
            k_nxt = k_q + KIW'(1);
        end
        nxt_last = (i_nxt == LAST_ROW) && (k_nxt == last_k_q);
        lane_clr = !I_SYNC_RSTN || ((state_q == StIdle) && I_START_FLAG);
        lane_en  = (state_q == StRun);
        x_cur    = I_X_MATRIX[i_q][k_q];
    end

    for (genvar c = 0; c < SA_C; c++) begin : g_lane
        sa_mac_lane #(
            .D_W   (D_W),
            .ACC_W (ACC_W),
            .FRAC  (FRAC)
        ) u_lane (
            .clk_i  (I_CLK),
            .rst_ni (I_ASYN_RSTN),
            .clr_i  (lane_clr),
            .en_i   (lane_en),
            .last_i (row_end),
            .x_i    (x_cur),
            .w_i    (I_W_MATRIX[k_q][c]),
            .res_o  (row_res[c])
        );
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q  <= StIdle;
            i_q      <= '0;
            k_q      <= '0;
            last_k_q <= '0;
            vld_q    <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            out_q    <= '0;
        end else if (!I_SYNC_RSTN) begin
            state_q  <= StIdle;
            i_q      <= '0;
            k_q      <= '0;
            last_k_q <= '0;
            vld_q    <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    vld_q   <= 1'b0;
                    shift_q <= 1'b0;
                    if (I_START_FLAG) begin
                        busy_q   <= 1'b1;
                        i_q      <= '0;
                        k_q      <= '0;
                        last_k_q <= last_k_w;
                        if (m_zero) begin
                            state_q  <= StDone;
                            shift_q  <= 1'b1;
                            last_k_q <= '0;
                            out_q    <= '0;
                        end else begin
                            state_q <= StRun;
                            shift_q <= (SA_R == 1) && (last_k_w == '0);
                        end
                    end
                end
                StRun: begin
                    if (row_end) begin
                        out_q[i_q] <= row_res;
                    end
                    if (job_end) begin
                        state_q <= StDone;
                        vld_q   <= 1'b1;
                        shift_q <= 1'b0;
                        i_q     <= '0;
                        k_q     <= '0;
                    end else begin
                        i_q     <= i_nxt;
                        k_q     <= k_nxt;
                        shift_q <= nxt_last;
                    end
                end
                StDone: begin
                    // A zero-length job arrives here without vld set and spends one extra cycle.
                    shift_q <= 1'b0;
                    if (vld_q) begin
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        vld_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign O_OUT_VLD  = vld_q;
    assign O_PE_SHIFT = shift_q;
    assign O_BUSY     = busy_q;
    assign O_OUT      = out_q;

endmodule

// File: tb/tb_sa_seq_responder.sv
// Self-checking bench: two responders (FRAC 0 and FRAC 2) share stimulus and are compared
// against a plain-arithmetic matrix-product model and cycle-count expectations.
module tb_sa_seq_responder;

    localparam int unsigned D_W   = 8;
    localparam int unsigned SA_R  = 16;
    localparam int unsigned SA_C  = 16;
    localparam int unsigned K_MAX = 128;
    localparam int          BUDGET = 3000;

    typedef logic [0:SA_R-1][0:K_MAX-1][D_W-1:0] x_t;
    typedef logic [0:K_MAX-1][0:SA_C-1][D_W-1:0] w_t;
    typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0]  o_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_rstn;
    logic       start;
    logic [7:0] m_dim;
    x_t         x_mat;
    w_t         w_mat;
    logic       vld0, shift0, busy0;
    logic       vld2, shift2, busy2;
    o_t         out0, out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sa_seq_responder #(
        .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX), .FRAC(0)
    ) u_dut0 (
        .I_CLK(clk), .I_ASYN_RSTN(rst_n), .I_SYNC_RSTN(sync_rstn), .I_START_FLAG(start),
        .I_M_DIM(m_dim), .I_X_MATRIX(x_mat), .I_W_MATRIX(w_mat),
        .O_OUT_VLD(vld0), .O_PE_SHIFT(shift0), .O_BUSY(busy0), .O_OUT(out0)
    );

    sa_seq_responder #(
        .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX), .FRAC(2)
    ) u_dut2 (
        .I_CLK(clk), .I_ASYN_RSTN(rst_n), .I_SYNC_RSTN(sync_rstn), .I_START_FLAG(start),
        .I_M_DIM(m_dim), .I_X_MATRIX(x_mat), .I_W_MATRIX(w_mat),
        .O_OUT_VLD(vld2), .O_PE_SHIFT(shift2), .O_BUSY(busy2), .O_OUT(out2)
    );

    // Reference: sat((X x W) >>> frac) over the clamped inner dimension.
    function automatic o_t ref_out(input x_t x, input w_t w, input int m, input int frac);
        o_t     r;
        longint s;
        longint hi = (longint'(1) <<< (D_W - 1)) - 1;
        longint lo = -(longint'(1) <<< (D_W - 1));
        int     meff = (m > int'(K_MAX)) ? int'(K_MAX) : m;
        for (int i = 0; i < SA_R; i++) begin
            for (int c = 0; c < SA_C; c++) begin
                s = 0;
                for (int k = 0; k < meff; k++) begin
                    s += longint'($signed(x[i][k])) * longint'($signed(w[k][c]));
                end
                s = s >>> frac;
                if (s > hi) s = hi;
                if (s < lo) s = lo;
                r[i][c] = s[D_W-1:0];
            end
        end
        return r;
    endfunction

    function automatic int ref_shift(input int m);
        int meff = (m > int'(K_MAX)) ? int'(K_MAX) : m;
        return (meff == 0) ? 1 : int'(SA_R) * meff;
    endfunction

    function automatic int ref_vld(input int m);
        return ref_shift(m) + 1;
    endfunction

    function automatic string diff_str(input o_t a, input o_t b);
        for (int i = 0; i < SA_R; i++) begin
            for (int c = 0; c < SA_C; c++) begin
                if (a[i][c] !== b[i][c]) begin
                    return $sformatf("[%0d][%0d] got %0d need %0d", i, c,
                                     $signed(a[i][c]), $signed(b[i][c]));
                end
            end
        end
        return "no element differs";
    endfunction

    task automatic fill_random(input int lo, input int hi);
        int v;
        for (int i = 0; i < SA_R; i++) begin
            for (int k = 0; k < K_MAX; k++) begin
                v = int'($urandom_range(0, hi - lo)) + lo;
                x_mat[i][k] = v[D_W-1:0];
            end
        end
        for (int k = 0; k < K_MAX; k++) begin
            for (int c = 0; c < SA_C; c++) begin
                v = int'($urandom_range(0, hi - lo)) + lo;
                w_mat[k][c] = v[D_W-1:0];
            end
        end
    endtask

    // Starts a job from a negedge and measures strobes; returns at the negedge of the vld cycle.
    task automatic do_job(input int poke_a, input int poke_b, output int shift_cyc,
                          output int shift_n, output int vld_cyc, output int vld2_cyc,
                          output int busy_bad);
        shift_cyc = -1; shift_n = 0; vld_cyc = -1; vld2_cyc = -1; busy_bad = 0;
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            start = (cyc == poke_a) || (cyc == poke_b);
            if (shift0 === 1'b1) begin
                shift_n++;
                if (shift_cyc < 0) shift_cyc = cyc;
            end
            if (busy0 !== 1'b1 || busy2 !== 1'b1) busy_bad++;
            if (vld2 === 1'b1 && vld2_cyc < 0) vld2_cyc = cyc;
            if (vld0 === 1'b1) begin
                vld_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic check_outputs_and_timing(input string name, input int m, input int sc,
                                            input int sn, input int vc, input int v2c,
                                            input int bb);
        o_t exp0 = ref_out(x_mat, w_mat, m, 0);
        o_t exp2 = ref_out(x_mat, w_mat, m, 2);
        checks++;
        if (out0 !== exp0) begin
            errors++;
            $display("FAIL %s O_OUT(frac0) %s", name, diff_str(out0, exp0));
        end
        checks++;
        if (out2 !== exp2) begin
            errors++;
            $display("FAIL %s O_OUT(frac2) %s", name, diff_str(out2, exp2));
        end
        checks++;
        if (sc !== ref_shift(m) || sn !== 1 || vc !== ref_vld(m) || v2c !== ref_vld(m)
            || bb !== 0) begin
            errors++;
            $display("FAIL %s timing: shift@%0d x%0d vld@%0d vld2@%0d busy_bad=%0d need shift@%0d x1 vld@%0d busy_bad=0",
                     name, sc, sn, vc, v2c, bb, ref_shift(m), ref_vld(m));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sync_rstn = 1'b1; start = 1'b0; m_dim = 8'd0;
        x_mat = '0; w_mat = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({vld0, shift0, busy0, vld2, shift2, busy2} !== 6'b0) begin
            errors++;
            $display("FAIL reset strobes: got %b need 000000",
                     {vld0, shift0, busy0, vld2, shift2, busy2});
        end
        checks++;
        if (out0 !== '0 || out2 !== '0) begin
            errors++;
            $display("FAIL reset O_OUT: %s", diff_str(out0, '0));
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int sc, sn, vc, v2c, bb;
        for (int i = 0; i < SA_R; i++) for (int k = 0; k < K_MAX; k++) x_mat[i][k] = 8'd1;
        for (int k = 0; k < K_MAX; k++) for (int c = 0; c < SA_C; c++) w_mat[k][c] = 8'd1;
        m_dim = 8'd16;
        do_job(-1, -1, sc, sn, vc, v2c, bb);
        check_outputs_and_timing("basic", 16, sc, sn, vc, v2c, bb);
        checks++;
        if (out0[7][9] !== 8'd16 || out2[7][9] !== 8'd4) begin
            errors++;
            $display("FAIL basic element: got %0d/%0d need 16/4", out0[7][9], out2[7][9]);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL basic busy_after_vld: got %b need 0", busy0);
        end
    endtask

    task automatic test_saturation();
        int sc, sn, vc, v2c, bb;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < SA_R; i++) begin
                for (int k = 0; k < K_MAX; k++) begin
                    x_mat[i][k] = (p == 0) ? 8'h7F : (p == 1) ? 8'h80 : ((k % 2) ? 8'h01 : 8'hFF);
                end
            end
            for (int k = 0; k < K_MAX; k++)
                for (int c = 0; c < SA_C; c++) w_mat[k][c] = (p == 2) ? 8'h01 : 8'h7F;
            m_dim = 8'd16;
            do_job(-1, -1, sc, sn, vc, v2c, bb);
            check_outputs_and_timing($sformatf("saturation%0d", p), 16, sc, sn, vc, v2c, bb);
            @(negedge clk);
        end
    endtask

    task automatic test_identity();
        int sc, sn, vc, v2c, bb;
        fill_random(-128, 127);
        for (int i = 0; i < SA_R; i++) for (int k = 0; k < 16; k++) x_mat[i][k] = D_W'(i + k);
        for (int k = 0; k < 16; k++)
            for (int c = 0; c < SA_C; c++) w_mat[k][c] = (k == c) ? 8'd1 : 8'd0;
        m_dim = 8'd16;
        do_job(-1, -1, sc, sn, vc, v2c, bb);
        check_outputs_and_timing("identity", 16, sc, sn, vc, v2c, bb);
        checks++;
        if (out0[3][5] !== 8'd8 || out2[3][5] !== 8'd2 || out2[15][14] !== 8'd7) begin
            errors++;
            $display("FAIL identity elements: got %0d/%0d/%0d need 8/2/7",
                     out0[3][5], out2[3][5], out2[15][14]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sc, sn, vc, v2c, bb;
        fill_random(-8, 7);
        m_dim = 8'd16;
        do_job(50, 257, sc, sn, vc, v2c, bb);
        check_outputs_and_timing("busy_start", 16, sc, sn, vc, v2c, bb);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL busy_start ignored_at_vld: busy got %b%b need 00", busy0, busy2);
        end
        fill_random(-8, 7);
        m_dim = 8'd16;
        do_job(-1, -1, sc, sn, vc, v2c, bb);
        check_outputs_and_timing("back_to_back", 16, sc, sn, vc, v2c, bb);
        @(negedge clk);
    endtask

    task automatic test_clear_mid_job();
        int sc, sn, vc, v2c, bb;
        int vld_seen = 0;
        fill_random(-8, 7);
        m_dim = 8'd16;
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            sync_rstn = (cyc != 100);
        end
        @(negedge clk);
        sync_rstn = 1'b1;
        checks++;
        if (busy0 !== 1'b0 || busy2 !== 1'b0 || out0 !== '0 || out2 !== '0) begin
            errors++;
            $display("FAIL clear state: busy %b%b out0 %s", busy0, busy2, diff_str(out0, '0));
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (vld0 === 1'b1 || vld2 === 1'b1) vld_seen++;
        end
        checks++;
        if (vld_seen !== 0) begin
            errors++;
            $display("FAIL clear no_vld: got %0d vld cycles need 0", vld_seen);
        end
        m_dim = 8'($urandom_range(1, 16));
        do_job(-1, -1, sc, sn, vc, v2c, bb);
        check_outputs_and_timing("after_clear", int'(m_dim), sc, sn, vc, v2c, bb);
        @(negedge clk);
    endtask

    task automatic test_boundary_m();
        int sc, sn, vc, v2c, bb;
        int mlist[2] = '{0, 200};
        foreach (mlist[j]) begin
            fill_random(-2, 1);
            m_dim = 8'(mlist[j]);
            do_job(-1, -1, sc, sn, vc, v2c, bb);
            check_outputs_and_timing($sformatf("boundary_m%0d", mlist[j]), mlist[j],
                                     sc, sn, vc, v2c, bb);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int sc, sn, vc, v2c, bb;
        int m;
        for (int n = 0; n < 4; n++) begin
            fill_random(-8, 7);
            m = int'($urandom_range(1, 24));
            m_dim = 8'(m);
            do_job(-1, -1, sc, sn, vc, v2c, bb);
            check_outputs_and_timing($sformatf("random%0d_m%0d", n, m), m, sc, sn, vc, v2c, bb);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_identity();
        test_back_to_back();
        test_clear_mid_job();
        test_boundary_m();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
